// File: rtl/mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_2p
// Description : Round-robin arbiter sharing one single-port RAM between two
//               requesters. One access at a time through a three-state FSM
//               (IDLE -> ISSUE -> [RWAIT] -> IDLE). Writes take two cycles,
//               reads take three, and read data returns with a one-cycle
//               rvalid pulse on the requesting port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_2p #(
    parameter int AW = 7,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    // FSM encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_rwait = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_grant;      // a winner is taken this cycle
    logic          w_pick1;      // winner is port 1 (only meaningful with w_grant)

    logic          r_win;        // port owning the access in flight
    logic          r_we;         // access in flight is a write
    logic          r_last_p1;    // port 1 won the most recent grant
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and round-robin winner selection. A lone request
    // wins outright; on a tie the port that did not win last time wins.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pick1     = req1 & (~req0 | ~r_last_p1);
        case (r_state)
            c_st_idle: begin
                if (req0 | req1) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                w_state_nxt = r_we ? c_st_idle : c_st_rwait;
            end
            c_st_rwait: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Access capture on grant, priority pointer, and read-data return.
    // mem_addr/mem_din only load on a grant so they hold between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_last_p1  <= 1'b1;   // makes port 0 win the first tie
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (w_grant) begin
                r_win      <= w_pick1;
                r_last_p1  <= w_pick1;
                r_we       <= w_pick1 ? we1    : we0;
                r_mem_addr <= w_pick1 ? addr1  : addr0;
                r_mem_din  <= w_pick1 ? wdata1 : wdata0;
            end
            if (r_state == c_st_rwait) begin
                if (r_win) begin
                    r_rdata1  <= mem_dout;
                    r_rvalid1 <= 1'b1;
                end else begin
                    r_rdata0  <= mem_dout;
                    r_rvalid0 <= 1'b1;
                end
            end
        end
    end

    // Grant and write strobe are both the ISSUE cycle of the owning access
    assign gnt0     = (r_state == c_st_issue) & ~r_win;
    assign gnt1     = (r_state == c_st_issue) &  r_win;
    assign mem_wen  = (r_state == c_st_issue) &  r_we;
    assign busy     = (r_state != c_st_idle);
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_2p.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter_2p
// Description : Self-checking bench for mem_arbiter_2p. A reference model
//               predicts each grant (port, cycle, RAM fields) and each read
//               return from the arbitration rules and a plain memory array;
//               a negedge monitor pops and compares whenever the DUT shows a
//               grant or rvalid. Directed scenarios then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_2p;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_wen;
    logic [DW-1:0] rdata0, rdata1, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter_2p #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Power-on contents of the RAM (also the model's starting image)
    function automatic logic [DW-1:0] pat(input int i);
        logic [DW-1:0] v;
        v = DW'(i * 29 + 3);
        if (i == 5) v = 8'h11;
        if (i == 6) v = 8'h22;
        return v;
    endfunction

    // Single-port RAM: registered read-first output
    logic [DW-1:0] ram [0:NW-1];
    bit            ram_loaded;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < NW; i++) ram[i] <= pat(i);
            ram_loaded <= 1'b1;
        end else begin
            mem_dout <= ram[mem_addr];
            if (mem_wen) ram[mem_addr] <= mem_din;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        longint        tag;
    } gnt_t;
    typedef struct {
        logic [DW-1:0] data;
        longint        tag;
    } rd_t;

    gnt_t          exp_gnt_q[$];
    rd_t           exp_rd0[$];
    rd_t           exp_rd1[$];
    logic [DW-1:0] m_mem [0:NW-1];
    longint        k_edge   = 0;  // index of the latest rising edge
    longint        m_free   = 0;  // first edge at which the arbiter can sample again
    bit            rst_edge = 1'b0;
    int            m_last   = 1;  // port of the previous grant

    initial begin
        int   p;
        bit   w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < NW; i++) m_mem[i] = pat(i);
        forever begin
            @(posedge clk);
            k_edge++;
            rst_edge = rst;
            if (rst) begin
                m_free = k_edge + 1;
                m_last = 1;
                exp_gnt_q.delete();
                exp_rd0.delete();
                exp_rd1.delete();
            end else if (k_edge >= m_free && (req0 || req1)) begin
                if (req0 && req1) p = (m_last == 0) ? 1 : 0;
                else              p = req1 ? 1 : 0;
                m_last = p;
                w = (p == 1) ? we1    : we0;
                a = (p == 1) ? addr1  : addr0;
                d = (p == 1) ? wdata1 : wdata0;
                exp_gnt_q.push_back('{port: p, we: w, addr: a, data: d, tag: k_edge});
                if (w) begin
                    m_mem[a] = d;
                    m_free   = k_edge + 2;
                end else begin
                    if (p == 1) exp_rd1.push_back('{data: m_mem[a], tag: k_edge + 2});
                    else        exp_rd0.push_back('{data: m_mem[a], tag: k_edge + 2});
                    m_free = k_edge + 3;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, k_edge, act, exp);
        end
    endtask

    task automatic miss(input string name, input longint tag);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got nothing, expected event at edge %0d", name, tag);
    endtask

    // ---------------- monitor ----------------
    initial begin
        gnt_t g;
        rd_t  r;
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                chk("rst_gnt0", gnt0, 0);       chk("rst_gnt1", gnt1, 0);
                chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
                chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
                chk("rst_mem_wen", mem_wen, 0); chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_din", mem_din, 0); chk("rst_busy", busy, 0);
            end else begin
                chk("gnt_onehot", gnt0 & gnt1, 0);
                chk("wen_outside_grant", mem_wen & ~(gnt0 | gnt1), 0);
                chk("busy", busy, k_edge <= m_free - 2);
                if (gnt0 || gnt1) begin
                    if (exp_gnt_q.size() == 0) begin
                        chk("unexpected_gnt", {gnt1, gnt0}, 0);
                    end else begin
                        g = exp_gnt_q.pop_front();
                        chk("gnt_port", gnt1, g.port);
                        chk("gnt_cycle", k_edge, g.tag);
                        chk("gnt_mem_wen", mem_wen, g.we);
                        chk("gnt_mem_addr", mem_addr, g.addr);
                        if (g.we) chk("gnt_mem_din", mem_din, g.data);
                    end
                end else if (exp_gnt_q.size() > 0 && exp_gnt_q[0].tag <= k_edge) begin
                    g = exp_gnt_q.pop_front();
                    miss("missing_gnt", g.tag);
                end
                if (rvalid0) begin
                    if (exp_rd0.size() == 0) chk("unexpected_rvalid0", rvalid0, 0);
                    else begin
                        r = exp_rd0.pop_front();
                        chk("rdata0", rdata0, r.data);
                        chk("rvalid0_cycle", k_edge, r.tag);
                    end
                end else if (exp_rd0.size() > 0 && exp_rd0[0].tag <= k_edge) begin
                    r = exp_rd0.pop_front();
                    miss("missing_rvalid0", r.tag);
                end
                if (rvalid1) begin
                    if (exp_rd1.size() == 0) chk("unexpected_rvalid1", rvalid1, 0);
                    else begin
                        r = exp_rd1.pop_front();
                        chk("rdata1", rdata1, r.data);
                        chk("rvalid1_cycle", k_edge, r.tag);
                    end
                end else if (exp_rd1.size() > 0 && exp_rd1[0].tag <= k_edge) begin
                    r = exp_rd1.pop_front();
                    miss("missing_rvalid1", r.tag);
                end
            end
        end
    end

    // ---------------- requester drivers ----------------
    task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic drop(input int p);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? gnt0 : gnt1;
    endfunction

    // Present a request and hold it until granted; returns at the negedge
    // of the grant cycle with the request still asserted.
    task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        set_req(p, w, a, d);
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_of(p) && n < 100);
        if (!gnt_of(p)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_timeout port %0d: got no gnt in %0d cycles, expected a gnt", p, n);
        end
    endtask

    task automatic rand_op(input int p);
        logic [AW-1:0] a;
        int            sel;
        int            gap;
        sel = $urandom_range(0, 9);
        if (sel == 0)      a = '0;
        else if (sel == 1) a = '1;
        else               a = AW'($urandom_range(0, NW - 1));
        issue(p, 1'($urandom_range(0, 1)), a, DW'($urandom_range(0, 255)));
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
            drop(p);
            repeat (gap) @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Simultaneous reads right after reset: port 0 first, then port 1
        fork
            begin issue(0, 1'b0, 7'd5, 8'h00); drop(0); end
            begin issue(1, 1'b0, 7'd6, 8'h00); drop(1); end
        join
        repeat (4) @(negedge clk);

        // Write then read on port 0
        issue(0, 1'b1, 7'd12, 8'd123); drop(0);
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 7'd12, 8'h00); drop(0);
        repeat (4) @(negedge clk);

        // Both ports writing continuously: grants must alternate
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 1'b1, AW'(20 + i), DW'(8'hA0 + i)); drop(0); end
            begin for (int j = 0; j < 4; j++) issue(1, 1'b1, AW'(40 + j), DW'(8'hB0 + j)); drop(1); end
        join
        repeat (3) @(negedge clk);

        // Boundary addresses via port 1
        issue(1, 1'b1, 7'd0,   8'hAA);
        issue(1, 1'b1, 7'd127, 8'h55);
        issue(1, 1'b0, 7'd0,   8'h00);
        issue(1, 1'b0, 7'd127, 8'h00); drop(1);
        repeat (4) @(negedge clk);

        // One-cycle req1 pulse while port 0 owns the RAM: must be ignored
        issue(0, 1'b0, 7'd40, 8'h00); drop(0);
        req1 = 1'b1; we1 = 1'b1; addr1 = 7'd99; wdata1 = 8'h77;
        @(negedge clk);
        req1 = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during RWAIT of a port 0 read; afterwards a tie goes to port 0
        issue(0, 1'b0, 7'd33, 8'h00); drop(0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fork
            begin issue(0, 1'b0, 7'd21, 8'h00); drop(0); end
            begin issue(1, 1'b0, 7'd41, 8'h00); drop(1); end
        join
        repeat (4) @(negedge clk);

        // Randomized traffic from both requesters
        fork
            begin for (int i = 0; i < 30; i++) rand_op(0); drop(0); end
            begin for (int j = 0; j < 30; j++) rand_op(1); drop(1); end
        join

        repeat (10) @(negedge clk);
        chk("drain_gnt_q",  exp_gnt_q.size(), 0);
        chk("drain_rd0_q",  exp_rd0.size(), 0);
        chk("drain_rd1_q",  exp_rd1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter_2p.md
MEM_ARBITER_2P -- requirements
Module: mem_arbiter_2p

Interface
REQ-001 Parameter AW, default 7, RAM address width (128 words).
REQ-002 Parameter DW, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by reqN.
REQ-007 addr0, addr1  input  AW each  access address.
REQ-008 wdata0, wdata1  input  DW each  write data.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse: request accepted.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle pulse: rdataN holds read data.
REQ-011 rdata0, rdata1  output  DW each  read data, held until the next rvalid for that port.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 mem_wen  output  1  write enable to the single-port RAM.
REQ-014 mem_addr  output  AW  RAM address.
REQ-015 mem_din  output  DW  RAM write data.
REQ-016 mem_dout  input  DW  RAM read data, valid the cycle after the edge that samples mem_addr with mem_wen=0.

Function
REQ-017 The block shall share one single-port AW x DW RAM between two requesters, one access at a time.
REQ-018 The FSM shall have exactly three states: IDLE, ISSUE, RWAIT.
REQ-019 IDLE: if any reqN=1 at an edge, pick a winner, register its we/addr/wdata onto mem_* and go to ISSUE; otherwise stay in IDLE.
REQ-020 Winner selection is round-robin: one request wins outright; on a tie the port that did not win the previous grant wins.
REQ-021 The priority pointer shall update only on a grant; after reset, port 0 wins the first tie.
REQ-022 gntN shall pulse high for exactly the ISSUE cycle of the winning port; at most one gnt is high in any cycle.
REQ-023 ISSUE, write: mem_wen=1 for this cycle only, then IDLE; no rvalid is produced.
REQ-024 ISSUE, read: mem_wen=0, then RWAIT.
REQ-025 RWAIT: capture mem_dout into rdataN of the winning port, pulse rvalidN in the following cycle, and return to IDLE.
REQ-026 Latency from req sampled in IDLE (edge t): gnt and mem access in cycle t+1; read data and rvalid in cycle t+3.
REQ-027 Throughput: one write every 2 cycles and one read every 3 cycles, with back-to-back grants possible.
REQ-028 Requesters shall hold reqN/weN/addrN/wdataN stable until gntN; fields are sampled only in IDLE.
REQ-029 A request deasserted before it is sampled in IDLE shall be ignored, with no side effects.
REQ-030 A request still high in the cycle after gntN shall be treated as a new request.
REQ-031 Requests arriving during ISSUE or RWAIT wait; they are arbitrated when the FSM next samples IDLE.
REQ-032 mem_addr and mem_din shall hold their last value outside ISSUE; mem_wen shall be 0 outside ISSUE.
REQ-033 Address wrap does not apply: addresses 0 and 2^AW-1 are both legal with no special handling.

Reset
REQ-034 With rst=1 at an edge: state=IDLE, gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_wen=0, mem_addr=0, mem_din=0, busy=0, pointer favours port 0.
REQ-035 Reset asserted in ISSUE or RWAIT shall abort the access: no rvalid, and a write in progress is not guaranteed.
REQ-036 Requests present during reset are ignored; arbitration starts at the first edge with rst=0.

Verification
REQ-037 Single write then read on port 0: write addr 12 = 123, then read addr 12 -> gnt0 pulses at t+1 each time; rdata0=123 with rvalid0 at t+3 of the read.
REQ-038 Simultaneous reads after reset: port 0 reads addr 5 (=0x11), port 1 reads addr 6 (=0x22) -> gnt0 first, rdata0=0x11, then gnt1, rdata1=0x22, with no overlap.
REQ-039 Both ports write continuously for 8 grants -> grants alternate 0,1,0,1,...; mem_wen high only in grant cycles.
REQ-040 Boundary addresses: write 0=0xAA and 127=0x55 via port 1, then read both back -> 0xAA and 0x55.
REQ-041 Reset asserted in RWAIT of a port 0 read -> no rvalid0; all outputs at reset values; next tie is won by port 0.
REQ-042 Request dropped while busy: req1 pulsed for one cycle during a port 0 access -> no gnt1, no mem activity for port 1.
